// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with valid/ready input FIFO
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter value");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;

    assign s_ready     = (r_count != (AW + 1)'(FIFO_DEPTH));
    assign w_push      = s_valid && s_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_bit_end   = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == IW'(STOP_BITS - 1));
    // The head word leaves the FIFO when a new frame starts, either from idle or back-to-back.
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);

    assign tx         = r_tx;
    assign tx_done    = r_tx_done;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            if (w_pop) begin
                r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity <= (^w_head) ^ 1'(PARITY_ODD);
`endif
            end
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_pop) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= S_PARITY;
`else
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (w_frame_end) begin
                            r_tx_done <= 1'b1;
                            r_bit_idx <= '0;
                            r_tx      <= !w_pop;
                            r_state   <= w_pop ? S_START : S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (8N1 and 7-bit/2-stop instances)
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic tx;
        logic first;
        logic last;
    } samp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid_a = 1'b0;
    logic [7:0] s_data_a = '0;
    logic       s_ready_a, tx_a, busy_a, done_a;
    logic [2:0] cnt_a;
    logic       s_valid_b = 1'b0;
    logic [6:0] s_data_b = '0;
    logic       s_ready_b, tx_b, busy_b, done_b;
    logic [2:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pend_a [$];
    logic [6:0] pend_b [$];
    samp_t      line_a [$];
    samp_t      line_b [$];
    int         m_cnt  [2];
    bit         m_done [2];

    always #5 clock = ~clock;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) u_a (
        .clock(clock), .reset(reset), .s_valid(s_valid_a), .s_data(s_data_a), .s_ready(s_ready_a),
        .tx(tx_a), .busy(busy_a), .tx_done(done_a), .fifo_count(cnt_a));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) u_b (
        .clock(clock), .reset(reset), .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
        .tx(tx_b), .busy(busy_b), .tx_done(done_b), .fifo_count(cnt_b));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expand one word into per-cycle expected line levels, appended after any frame already queued.
    task automatic append_frame(input int d, input logic [8:0] word);
        int         nd;
        int         ns;
        int         nb;
        logic       par;
        logic [15:0] bits;
        samp_t      s;
        nd   = (d == 0) ? 8 : 7;
        ns   = (d == 0) ? 1 : 2;
        par  = (d == 0) ? 1'b0 : 1'b1;
        bits = '0;
        nb   = 1;
        for (int i = 0; i < nd; i++) begin
            bits[nb] = word[i];
            par      = par ^ word[i];
            nb++;
        end
        if (PAR_EN) begin
            bits[nb] = par;
            nb++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                s.tx    = bits[b];
                s.first = (b == 0 && c == 0);
                s.last  = (b == nb - 1 && c == CPB - 1);
                if (d == 0) line_a.push_back(s);
                else        line_b.push_back(s);
            end
        end
    endtask

    task automatic model_edge(input int d, input bit acc, input logic [8:0] word,
                              output logic e_tx, output logic e_busy, output logic e_done);
        samp_t s;
        bit    have;
        e_done    = m_done[d];
        m_done[d] = 1'b0;
        have      = (d == 0) ? (line_a.size() > 0) : (line_b.size() > 0);
        if (have) begin
            s      = (d == 0) ? line_a.pop_front() : line_b.pop_front();
            e_tx   = s.tx;
            e_busy = 1'b1;
            if (s.first) m_cnt[d]--;
            if (s.last)  m_done[d] = 1'b1;
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end
        if (acc) begin
            m_cnt[d]++;
            append_frame(d, word);
        end
    endtask

    task automatic step(input bit do_rst);
        bit         acc [2];
        logic [8:0] word [2];
        logic       e_tx, e_busy, e_done;
        reset = do_rst;
        if (do_rst) begin
            pend_a.delete();
            pend_b.delete();
        end
        s_valid_a = (pend_a.size() > 0);
        s_data_a  = s_valid_a ? pend_a[0] : 8'($urandom);
        s_valid_b = (pend_b.size() > 0);
        s_data_b  = s_valid_b ? pend_b[0] : 7'($urandom);
        word[0]   = {1'b0, s_data_a};
        word[1]   = {2'b00, s_data_b};
        acc[0]    = s_valid_a && (m_cnt[0] != DEPTH);
        acc[1]    = s_valid_b && (m_cnt[1] != DEPTH);
        @(posedge clock);
        #1;
        if (acc[0]) void'(pend_a.pop_front());
        if (acc[1]) void'(pend_b.pop_front());
        if (do_rst) begin
            line_a.delete();
            line_b.delete();
            m_cnt  = '{0, 0};
            m_done = '{0, 0};
        end
        for (int d = 0; d < 2; d++) begin
            if (do_rst) begin
                e_tx   = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b0;
            end else begin
                model_edge(d, acc[d], word[d], e_tx, e_busy, e_done);
            end
            chk($sformatf("tx[%0d]", d),         16'(d == 0 ? tx_a : tx_b),           16'(e_tx));
            chk($sformatf("busy[%0d]", d),       16'(d == 0 ? busy_a : busy_b),       16'(e_busy));
            chk($sformatf("tx_done[%0d]", d),    16'(d == 0 ? done_a : done_b),       16'(e_done));
            chk($sformatf("fifo_count[%0d]", d), 16'(d == 0 ? cnt_a : cnt_b),         16'(m_cnt[d]));
            chk($sformatf("s_ready[%0d]", d),    16'(d == 0 ? s_ready_a : s_ready_b), 16'(m_cnt[d] != DEPTH));
        end
    endtask

    initial begin
        m_cnt  = '{0, 0};
        m_done = '{0, 0};

        step(1'b1);
        step(1'b1);

        // Single frame from an empty FIFO.
        pend_a.push_back(8'hA5);
        repeat (50) step(1'b0);

        // Three queued words, back-to-back frames.
        pend_a.push_back(8'h01);
        pend_a.push_back(8'h02);
        pend_a.push_back(8'h03);
        repeat (130) step(1'b0);

        // Valid held high long enough to fill the FIFO and stall on s_ready.
        pend_a.push_back(8'hC3);
        pend_a.push_back(8'h3C);
        pend_a.push_back(8'hF0);
        pend_a.push_back(8'h0F);
        pend_a.push_back(8'h81);
        pend_a.push_back(8'h7E);
        repeat (270) step(1'b0);

        // 7-bit / 2-stop instance, and a parity-sensitive word on both.
        pend_b.push_back(7'h7F);
        pend_b.push_back(7'h07);
        pend_a.push_back(8'h07);
        repeat (110) step(1'b0);

        for (int i = 0; i < 4; i++) begin
            pend_a.push_back(8'($urandom));
            pend_b.push_back(7'($urandom));
        end
        repeat (230) step(1'b0);

        // Reset ten cycles into a frame with two words still queued.
        pend_a.push_back(8'h11);
        pend_a.push_back(8'h22);
        pend_a.push_back(8'h33);
        repeat (11) step(1'b0);
        chk("queued_before_reset", 16'(cnt_a), 16'd2);
        step(1'b1);
        repeat (60) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that replaces the fixed 8N1 single-byte transmitter.
- Generic data width and stop-bit count; optional parity.
- Valid/ready input handshake feeding an internal FIFO.
- Back-to-back frames with no idle gap when data is queued.
- Sits between the host-side byte producer and the serial pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit; must be >= 2
DATA_BITS, 8, data bits per frame; 5..9
STOP_BITS, 1, stop bits per frame; 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
PARITY_ODD, 0, parity sense (0 even, 1 odd); only used when UART_TX_PARITY_EN is defined

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
s_valid  in  1  producer has a word on s_data
s_data  in  DATA_BITS  word to transmit
s_ready  out  1  FIFO can accept a word; equals !full, driven combinationally from the FIFO count
tx  out  1  serial line; registered; idle high
busy  out  1  high while a frame is in progress (state != IDLE)
tx_done  out  1  one-cycle pulse at the end of each frame's final stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued

Behaviour:
- Reset values (clocked, has priority over everything):
  - tx=1, busy=0, tx_done=0.
  - FIFO emptied, so fifo_count=0 and s_ready=1.
  - State IDLE; bit counter and bit index cleared.
- Push: occurs on each edge where s_valid && s_ready.
  - When full, s_ready=0 even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- Every bit lasts exactly CLKS_PER_BIT cycles.
  - Per-bit counter runs 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
- IDLE, with fifo_count > 0 at an edge:
  - Pop the head word into the shift register.
  - tx<=0, state<=START, counter<=0.
  - Otherwise tx stays 1.
  - Latency: word written into an empty FIFO at edge N drives tx low after edge N+1.
- START: tx=0 for one bit time, then DATA.
- DATA: LSB first. Bit index runs 0..DATA_BITS-1, then PARITY (if enabled) or STOP.
- STOP: tx=1 for STOP_BITS bit times.
- At the last cycle of the final stop bit:
  - tx_done<=1 for exactly one cycle.
  - If the FIFO is non-empty, pop immediately and go to START (tx<=0); tx_done and the new start bit begin on the same edge, with no idle cycle between frames.
  - Else go to IDLE; busy falls on the same edge.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- The input word is captured at pop. Later FIFO writes never alter the frame in flight.
- Reset mid-frame:
  - tx returns to 1 on the next edge; the frame is aborted.
  - No tx_done pulse; queued words are discarded.
- s_data while s_valid=0 is don't-care.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP, lasting one bit time.
  - Parity bit = XOR of all DATA_BITS bits of the frame word, XOR PARITY_ODD.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - PARITY_ODD is ignored; no parity logic is synthesised.

Test Plan:
1. CLKS_PER_BIT=4, defaults, push 0xA5 into empty FIFO at edge N -> tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then tx high 4 cycles. tx_done pulses once, 40 cycles after the start-bit edge.
2. Push 0x01, 0x02, 0x03 back-to-back -> three contiguous 40-cycle frames with no idle cycle between them; tx_done pulses 3 times; fifo_count decrements at each frame start.
3. FIFO_DEPTH=4, hold s_valid=1 during a frame -> 4 words accepted then s_ready=0. Push attempted on the cycle of a pop is rejected. s_ready rises the cycle after a pop.
4. STOP_BITS=2, DATA_BITS=7, send 0x7F -> start, seven 1s, 8 cycles high; frame 40 cycles total.
5. Assert reset at cycle 10 of a frame with 2 words queued -> tx=1, busy=0, fifo_count=0 next edge; no tx_done; line stays idle afterwards.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0.
